// File: rtl/dispatch_scheduler_pkg.sv
// Shared types for the dispatch scheduler: micro-op layout, opcodes, FU steering, FSM states.
package dispatch_scheduler_pkg;

    localparam int unsigned GPR_IDX_SIZE = 5;
    localparam int unsigned IMM_W        = 64;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_ORR  = 4'h4,
        OP_EOR  = 4'h5,
        OP_LDUR = 4'h6,
        OP_STUR = 4'h7,
        OP_CBZ  = 4'h8,
        OP_B    = 4'h9,
        OP_HLT  = 4'hF
    } opcode_t;

    typedef enum logic {
        FU_ALU = 1'b0,
        FU_LS  = 1'b1
    } func_unit_t;

    typedef struct packed {
        opcode_t                 opcode;
        func_unit_t              fu;
        logic [GPR_IDX_SIZE-1:0] src1;
        logic [GPR_IDX_SIZE-1:0] src2;
        logic [GPR_IDX_SIZE-1:0] dst;
        logic [IMM_W-1:0]        imm;
        logic                    set_cc;
        logic                    w_enable;
    } dispatch_uop_t;

    typedef enum logic {
        SCHED_RUN    = 1'b0,
        SCHED_HALTED = 1'b1
    } sched_state_t;

    // Dispatching this micro-op stops the scheduler until a flush.
    function automatic logic is_halt(input dispatch_uop_t uop);
        return uop.opcode == OP_HLT;
    endfunction

endpackage

// File: rtl/uop_fifo.sv
// Circular micro-op FIFO with occupancy count, head read and synchronous flush.
module uop_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Status flags and qualified push/pop (never overflow or underflow).
    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == DepthC);
        do_push = push_i && !full_o && !flush_i;
        do_pop  = pop_i && !empty_o && !flush_i;
        count_o = count_q;
        data_o  = mem_q[rd_ptr_q];
    end

    // Pointer and occupancy next state; pointers wrap naturally since Depth is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; stale entries are never observed because reads are gated by count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// In-order dispatch buffer: queues decoded micro-ops, allocates ROB tags against a credit
// pool and steers the head to the ALU or load/store reservation station.
module dispatch_scheduler
    import dispatch_scheduler_pkg::*;
#(
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned ROB_SIZE = 16,
    parameter int unsigned TAG_W    = $clog2(ROB_SIZE)
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic                    in_uop_valid,
    input  dispatch_uop_t           in_uop,
    output logic                    out_uop_ready,
    input  logic                    in_alu_rs_ready,
    input  logic                    in_ls_rs_ready,
    output logic                    out_alu_valid,
    output logic                    out_ls_valid,
    output dispatch_uop_t           out_uop,
    output logic [TAG_W-1:0]        out_rob_tag,
    input  logic                    in_rob_retire,
    input  logic                    in_flush,
    output logic [$clog2(QDEPTH):0] out_count,
    output logic                    out_halted,
    output logic                    out_stalled
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
    localparam int unsigned CR_W  = TAG_W + 1;
    localparam logic [CR_W-1:0] ROB_SIZE_C = CR_W'(ROB_SIZE);

    sched_state_t     state_q, state_d;
    logic [CR_W-1:0]  credits_q, credits_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    dispatch_uop_t    head;
    logic [CNT_W-1:0] count;
    logic             empty, full;
    logic             offer, dispatch, push, pop, retire_ok;

    uop_fifo #(
        .Depth (QDEPTH),
        .Width ($bits(dispatch_uop_t))
    ) u_uop_fifo (
        .clk_i   (in_clk),
        .rst_ni  (in_rst_n),
        .flush_i (in_flush),
        .push_i  (push),
        .data_i  (in_uop),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    // Handshake and steering; valids never look at the RS ready inputs.
    always_comb begin
        offer         = (state_q == SCHED_RUN) && !empty && (credits_q != '0);
        out_alu_valid = offer && (head.fu == FU_ALU);
        out_ls_valid  = offer && (head.fu == FU_LS);
        dispatch      = (out_alu_valid && in_alu_rs_ready) || (out_ls_valid && in_ls_rs_ready);
        // Ready follows registered occupancy only, so a same-cycle pop cannot open a full queue.
        out_uop_ready = (state_q == SCHED_RUN) && !full;
        out_stalled   = !out_uop_ready;
        push          = in_uop_valid && out_uop_ready && !in_flush;
        pop           = dispatch && !in_flush;
        retire_ok     = in_rob_retire && (credits_q != ROB_SIZE_C);
    end

    // Visible status; payload reads as zero whenever nothing is buffered.
    always_comb begin
        out_uop     = empty ? '0 : head;
        out_rob_tag = tag_q;
        out_count   = count;
        out_halted  = (state_q == SCHED_HALTED);
    end

    // FSM, tag and credit next state; flush overrides every other event.
    always_comb begin
        state_d   = state_q;
        credits_d = credits_q;
        tag_d     = tag_q;
        if (in_flush) begin
            state_d   = SCHED_RUN;
            credits_d = ROB_SIZE_C;
            tag_d     = '0;
        end else begin
            if (dispatch) begin
                tag_d = tag_q + TAG_W'(1);
                if (is_halt(head)) state_d = SCHED_HALTED;
            end
            unique case ({dispatch, retire_ok})
                2'b10:   credits_d = credits_q - CR_W'(1);
                2'b01:   credits_d = credits_q + CR_W'(1);
                default: credits_d = credits_q;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= SCHED_RUN;
            credits_q <= ROB_SIZE_C;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            tag_q     <= tag_d;
        end
    end

    // A retire with no outstanding entries means the ROB and scheduler disagree.
    a_retire_at_full: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        !(in_rob_retire && !in_flush && (credits_q == ROB_SIZE_C)));

    a_credit_range: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        credits_q <= ROB_SIZE_C);

    a_one_target: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        !(out_alu_valid && out_ls_valid));

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Self-checking bench: vector table plus hand sequences, with an in-order dispatch scoreboard.
module tb_dispatch_scheduler;
    import dispatch_scheduler_pkg::*;

    logic          in_clk = 1'b0;
    logic          in_rst_n = 1'b0;
    logic          in_uop_valid = 1'b0;
    dispatch_uop_t in_uop = '0;
    logic          out_uop_ready;
    logic          in_alu_rs_ready = 1'b0;
    logic          in_ls_rs_ready = 1'b0;
    logic          out_alu_valid, out_ls_valid;
    dispatch_uop_t out_uop;
    logic [3:0]    out_rob_tag;
    logic          in_rob_retire = 1'b0;
    logic          in_flush = 1'b0;
    logic [2:0]    out_count;
    logic          out_halted, out_stalled;

    int total = 0;
    int bad = 0;
    dispatch_uop_t sb_q[$];
    logic [3:0]    exp_tag = 4'd0;

    dispatch_scheduler #(.QDEPTH(4), .ROB_SIZE(16)) dut (
        .in_clk          (in_clk),
        .in_rst_n        (in_rst_n),
        .in_uop_valid    (in_uop_valid),
        .in_uop          (in_uop),
        .out_uop_ready   (out_uop_ready),
        .in_alu_rs_ready (in_alu_rs_ready),
        .in_ls_rs_ready  (in_ls_rs_ready),
        .out_alu_valid   (out_alu_valid),
        .out_ls_valid    (out_ls_valid),
        .out_uop         (out_uop),
        .out_rob_tag     (out_rob_tag),
        .in_rob_retire   (in_rob_retire),
        .in_flush        (in_flush),
        .out_count       (out_count),
        .out_halted      (out_halted),
        .out_stalled     (out_stalled)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic dispatch_uop_t mk(input opcode_t op, input func_unit_t fu,
                                         input logic [4:0] dst, input logic [63:0] imm);
        dispatch_uop_t u;
        u          = '0;
        u.opcode   = op;
        u.fu       = fu;
        u.src1     = dst ^ 5'd1;
        u.src2     = dst ^ 5'd2;
        u.dst      = dst;
        u.imm      = imm;
        u.set_cc   = imm[0];
        u.w_enable = (fu == FU_ALU);
        return u;
    endfunction

    typedef struct {
        logic          v;
        dispatch_uop_t u;
        logic          ar, lr, ret, fl;
        logic          e_alu, e_ls, e_rdy, e_halt;
        int            e_cnt, e_cr;
    } vec_t;

    function automatic vec_t row(input logic v, input dispatch_uop_t u, input logic ar,
                                 input logic lr, input logic ret, input logic fl,
                                 input logic ea, input logic el, input logic er,
                                 input logic eh, input int ec, input int ecr);
        vec_t r;
        r.v = v; r.u = u; r.ar = ar; r.lr = lr; r.ret = ret; r.fl = fl;
        r.e_alu = ea; r.e_ls = el; r.e_rdy = er; r.e_halt = eh; r.e_cnt = ec; r.e_cr = ecr;
        return r;
    endfunction

    task automatic drive(input logic v, input dispatch_uop_t u, input logic ar, input logic lr,
                         input logic ret, input logic fl);
        in_uop_valid = v; in_uop = u; in_alu_rs_ready = ar; in_ls_rs_ready = lr;
        in_rob_retire = ret; in_flush = fl;
    endtask

    // Advance from the drive point of one cycle to the drive point of the next.
    task automatic next_cycle();
        @(posedge in_clk);
        #1;
    endtask

    // Scoreboard: every handshake must present the oldest accepted micro-op with the next tag.
    always @(negedge in_clk) begin
        if (in_rst_n && !in_flush &&
            ((out_alu_valid && in_alu_rs_ready) || (out_ls_valid && in_ls_rs_ready))) begin
            if (sb_q.size() == 0) begin
                check("sb_dispatch_with_empty_model", 128'(sb_q.size()), 128'd1);
            end else begin
                dispatch_uop_t e;
                e = sb_q.pop_front();
                check("sb_uop", out_uop, e);
                check("sb_tag", 128'(out_rob_tag), 128'(exp_tag));
                check("sb_ls_port", 128'(out_ls_valid), 128'(e.fu == FU_LS));
                check("sb_alu_port", 128'(out_alu_valid), 128'(e.fu == FU_ALU));
                exp_tag = exp_tag + 4'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[$];
        dispatch_uop_t nul, add3, stur, hlt, orr, sub9, ld, aop, xop, yop;
        dispatch_uop_t fu_u[5];
        dispatch_uop_t wr_u[17];

        nul  = '0;
        add3 = mk(OP_ADD,  FU_ALU, 5'd3,  64'h11);
        stur = mk(OP_STUR, FU_LS,  5'd4,  64'h20);
        hlt  = mk(OP_HLT,  FU_ALU, 5'd0,  64'h0);
        orr  = mk(OP_ORR,  FU_ALU, 5'd7,  64'h33);
        sub9 = mk(OP_SUB,  FU_ALU, 5'd9,  64'h45);
        ld   = mk(OP_LDUR, FU_LS,  5'd12, 64'h100);
        aop  = mk(OP_AND,  FU_ALU, 5'd13, 64'h57);
        xop  = mk(OP_EOR,  FU_ALU, 5'd14, 64'h61);
        yop  = mk(OP_ADD,  FU_ALU, 5'd15, 64'h72);
        for (int i = 0; i < 5; i++) fu_u[i] = mk(OP_SUB, FU_ALU, 5'(i + 5), 64'(i * 16 + 3));
        for (int i = 0; i < 17; i++) wr_u[i] = mk(OP_ADD, FU_ALU, 5'(i), 64'(i * 7 + 1));

        //           v  uop      ar lr rt fl   alu ls rdy hlt cnt cr
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  0, 0, 1, 0, 0, 16));
        tbl.push_back(row(1, add3,    1, 1, 0, 0,  0, 0, 1, 0, 0, 16));
        tbl.push_back(row(1, stur,    1, 1, 0, 0,  1, 0, 1, 0, 1, 16));
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  0, 1, 1, 0, 1, 15));
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  0, 0, 1, 0, 0, 14));
        // Fill with both stations blocked; fifth push waits for the first dispatch.
        tbl.push_back(row(1, fu_u[0], 0, 0, 0, 0,  0, 0, 1, 0, 0, 14));
        tbl.push_back(row(1, fu_u[1], 0, 0, 0, 0,  1, 0, 1, 0, 1, 14));
        tbl.push_back(row(1, fu_u[2], 0, 0, 0, 0,  1, 0, 1, 0, 2, 14));
        tbl.push_back(row(1, fu_u[3], 0, 0, 0, 0,  1, 0, 1, 0, 3, 14));
        tbl.push_back(row(1, fu_u[4], 0, 0, 0, 0,  1, 0, 0, 0, 4, 14));
        tbl.push_back(row(1, fu_u[4], 1, 0, 0, 0,  1, 0, 0, 0, 4, 14));
        tbl.push_back(row(1, fu_u[4], 0, 0, 0, 0,  1, 0, 1, 0, 3, 13));
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  1, 0, 0, 0, 4, 13));
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  1, 0, 1, 0, 3, 12));
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  1, 0, 1, 0, 2, 11));
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  1, 0, 1, 0, 1, 10));
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  0, 0, 1, 0, 0, 9));
        // Retires return credits one at a time.
        for (int i = 0; i < 7; i++) tbl.push_back(row(0, nul, 1, 1, 1, 0, 0, 0, 1, 0, 0, 9 + i));
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  0, 0, 1, 0, 0, 16));
        // Halt: ADD, HLT dispatch; ORR stays behind until flush.
        tbl.push_back(row(1, add3,    1, 1, 0, 0,  0, 0, 1, 0, 0, 16));
        tbl.push_back(row(1, hlt,     1, 1, 0, 0,  1, 0, 1, 0, 1, 16));
        tbl.push_back(row(1, orr,     1, 1, 0, 0,  1, 0, 1, 0, 1, 15));
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  0, 0, 0, 1, 1, 14));
        tbl.push_back(row(1, sub9,    1, 1, 0, 0,  0, 0, 0, 1, 1, 14));
        tbl.push_back(row(0, nul,     1, 1, 0, 1,  0, 0, 0, 1, 1, 14));
        tbl.push_back(row(0, nul,     1, 1, 0, 0,  0, 0, 1, 0, 0, 16));

        // Reset state, checked while reset is still asserted.
        #2;
        check("rst_alu_valid", 128'(out_alu_valid), 128'd0);
        check("rst_ls_valid", 128'(out_ls_valid), 128'd0);
        check("rst_ready", 128'(out_uop_ready), 128'd1);
        check("rst_stalled", 128'(out_stalled), 128'd0);
        check("rst_halted", 128'(out_halted), 128'd0);
        check("rst_tag", 128'(out_rob_tag), 128'd0);
        check("rst_uop", out_uop, 128'd0);
        check("rst_count", 128'(out_count), 128'd0);
        #10 in_rst_n = 1'b1;
        next_cycle();

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].u, tbl[i].ar, tbl[i].lr, tbl[i].ret, tbl[i].fl);
            if (tbl[i].v && tbl[i].e_rdy && !tbl[i].fl) sb_q.push_back(tbl[i].u);
            @(negedge in_clk);
            check($sformatf("r%0d_alu_valid", i), 128'(out_alu_valid), 128'(tbl[i].e_alu));
            check($sformatf("r%0d_ls_valid", i), 128'(out_ls_valid), 128'(tbl[i].e_ls));
            check($sformatf("r%0d_ready", i), 128'(out_uop_ready), 128'(tbl[i].e_rdy));
            check($sformatf("r%0d_stalled", i), 128'(out_stalled), 128'(!tbl[i].e_rdy));
            check($sformatf("r%0d_halted", i), 128'(out_halted), 128'(tbl[i].e_halt));
            check($sformatf("r%0d_count", i), 128'(out_count), 128'(tbl[i].e_cnt));
            check($sformatf("r%0d_credits", i), 128'(dut.credits_q), 128'(tbl[i].e_cr));
            next_cycle();
            if (tbl[i].fl) begin
                sb_q.delete();
                exp_tag = 4'd0;
            end
        end
        check("post_flush_tag", 128'(out_rob_tag), 128'd0);

        // Blocked LS head holds its payload; the ALU op behind it waits (no bypass).
        drive(1, ld, 1, 0, 0, 0);
        sb_q.push_back(ld);
        next_cycle();
        drive(1, aop, 1, 0, 0, 0);
        sb_q.push_back(aop);
        for (int c = 0; c < 3; c++) begin
            @(negedge in_clk);
            check($sformatf("blk%0d_ls_valid", c), 128'(out_ls_valid), 128'd1);
            check($sformatf("blk%0d_alu_valid", c), 128'(out_alu_valid), 128'd0);
            check($sformatf("blk%0d_uop", c), out_uop, ld);
            check($sformatf("blk%0d_tag", c), 128'(out_rob_tag), 128'd0);
            next_cycle();
            in_uop_valid = 1'b0;
        end
        in_ls_rs_ready = 1'b1;
        @(negedge in_clk);
        check("blk_ls_handshake", 128'(out_ls_valid), 128'd1);
        next_cycle();
        @(negedge in_clk);
        check("blk_alu_after_ls", 128'(out_alu_valid), 128'd1);
        check("blk_alu_tag", 128'(out_rob_tag), 128'd1);
        next_cycle();

        // Credit exhaustion and tag wrap.
        drive(0, nul, 1, 1, 0, 1);
        next_cycle();
        sb_q.delete();
        exp_tag = 4'd0;
        for (int i = 0; i < 16; i++) begin
            drive(1, wr_u[i], 1, 1, 0, 0);
            sb_q.push_back(wr_u[i]);
            next_cycle();
        end
        drive(0, nul, 1, 1, 0, 0);
        next_cycle();
        @(negedge in_clk);
        check("cr_exhausted", 128'(dut.credits_q), 128'd0);
        check("cr_tag_wrapped", 128'(out_rob_tag), 128'd0);
        next_cycle();
        drive(1, wr_u[16], 1, 1, 0, 0);
        sb_q.push_back(wr_u[16]);
        next_cycle();
        drive(0, nul, 1, 1, 0, 0);
        @(negedge in_clk);
        check("cr0_count", 128'(out_count), 128'd1);
        check("cr0_no_valid", 128'(out_alu_valid), 128'd0);
        check("cr0_ready", 128'(out_uop_ready), 128'd1);
        next_cycle();
        in_rob_retire = 1'b1;
        @(negedge in_clk);
        check("cr_retire_cycle_no_valid", 128'(out_alu_valid), 128'd0);
        next_cycle();
        in_rob_retire = 1'b0;
        @(negedge in_clk);
        check("cr_valid_after_retire", 128'(out_alu_valid), 128'd1);
        check("cr_wrap_tag0", 128'(out_rob_tag), 128'd0);
        next_cycle();
        @(negedge in_clk);
        check("cr_zero_again", 128'(dut.credits_q), 128'd0);
        next_cycle();

        // Flush collides with push, dispatch and retire.
        for (int i = 0; i < 3; i++) begin
            drive(0, nul, 1, 1, 1, 0);
            next_cycle();
        end
        drive(1, xop, 1, 1, 0, 0);
        sb_q.push_back(xop);
        next_cycle();
        drive(1, yop, 1, 1, 1, 1);
        @(negedge in_clk);
        check("fl_pre_credits", 128'(dut.credits_q), 128'd3);
        next_cycle();
        sb_q.delete();
        exp_tag = 4'd0;
        drive(0, nul, 1, 1, 0, 0);
        @(negedge in_clk);
        check("fl_count", 128'(out_count), 128'd0);
        check("fl_alu_valid", 128'(out_alu_valid), 128'd0);
        check("fl_ls_valid", 128'(out_ls_valid), 128'd0);
        check("fl_credits", 128'(dut.credits_q), 128'd16);
        check("fl_tag", 128'(out_rob_tag), 128'd0);
        check("fl_halted", 128'(out_halted), 128'd0);
        next_cycle();

        // Asynchronous reset in the middle of traffic.
        drive(1, add3, 1, 1, 0, 0);
        sb_q.push_back(add3);
        next_cycle();
        drive(1, sub9, 1, 1, 0, 0);
        sb_q.push_back(sub9);
        next_cycle();
        drive(1, orr, 0, 0, 0, 0);
        sb_q.push_back(orr);
        next_cycle();
        drive(0, nul, 0, 0, 0, 0);
        @(negedge in_clk);
        check("mid_count", 128'(out_count), 128'd2);
        check("mid_tag", 128'(out_rob_tag), 128'd1);
        #2 in_rst_n = 1'b0;
        #1;
        check("ar_count", 128'(out_count), 128'd0);
        check("ar_alu_valid", 128'(out_alu_valid), 128'd0);
        check("ar_ls_valid", 128'(out_ls_valid), 128'd0);
        check("ar_ready", 128'(out_uop_ready), 128'd1);
        check("ar_stalled", 128'(out_stalled), 128'd0);
        check("ar_halted", 128'(out_halted), 128'd0);
        check("ar_tag", 128'(out_rob_tag), 128'd0);
        check("ar_uop", out_uop, 128'd0);
        check("ar_credits", 128'(dut.credits_q), 128'd16);
        sb_q.delete();
        exp_tag = 4'd0;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        next_cycle();
        @(negedge in_clk);
        check("post_rst_count", 128'(out_count), 128'd0);
        check("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
